// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port memory: fetch (read only) and exec (read/write).
// Exec has priority; a saturating starve counter forces a fetch grant after IFU_STARVE_LIMIT exec wins.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH       = 12,
  parameter int DATA_WIDTH       = 12,
  parameter int IFU_STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_busy,
  output logic                  ifu_rd_valid,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_busy,
  output logic                  exec_rd_valid,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {IDLE, ISSUE_IFU_RD, ISSUE_EXEC_RD, ISSUE_EXEC_WR} state_e;

  localparam logic [3:0] STARVE_LIMIT = 4'(IFU_STARVE_LIMIT);

  state_e                  state_q, state_d;
  logic [3:0]              starve_q, starve_d;
  logic                    ifu_vld_q, ex_vld_q, ex_wr_q;
  logic [ADDR_WIDTH-1:0]   ifu_addr_q, ex_addr_q;
  logic [DATA_WIDTH-1:0]   ex_data_q;
  logic                    mem_rd_req_q, mem_wr_req_q;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr_q, mem_wr_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q;
  logic                    rd_ret_q, ret_ifu_q, err_q;

  logic                    ifu_new, ex_new, ifu_cand, ex_cand;
  logic                    grant_ifu, grant_ex, err_d;
  logic                    ex_wr_sel;
  logic [ADDR_WIDTH-1:0]   ifu_addr_sel, ex_addr_sel;
  logic [DATA_WIDTH-1:0]   ex_data_sel;

  // A request arriving while its slot is full is dropped; a new request competes on the edge it is sampled.
  always_comb begin
    ifu_new      = ifu_rd_req && !ifu_vld_q;
    ex_new       = (exec_rd_req || exec_wr_req) && !ex_vld_q;
    ifu_cand     = ifu_vld_q || ifu_new;
    ex_cand      = ex_vld_q || ex_new;
    ifu_addr_sel = ifu_vld_q ? ifu_addr_q : ifu_rd_addr;
    ex_wr_sel    = ex_vld_q ? ex_wr_q : exec_wr_req;
    ex_addr_sel  = ex_vld_q ? ex_addr_q : (exec_wr_req ? exec_wr_addr : exec_rd_addr);
    ex_data_sel  = ex_vld_q ? ex_data_q : exec_wr_data;

    grant_ex  = ex_cand && !(ifu_cand && (starve_q == STARVE_LIMIT));
    grant_ifu = ifu_cand && !grant_ex;

    state_d = IDLE;
    if (grant_ex)       state_d = ex_wr_sel ? ISSUE_EXEC_WR : ISSUE_EXEC_RD;
    else if (grant_ifu) state_d = ISSUE_IFU_RD;

    starve_d = starve_q;
    if (!ifu_cand || grant_ifu)                       starve_d = '0;
    else if (grant_ex && (starve_q != STARVE_LIMIT))  starve_d = starve_q + 4'd1;

    err_d = err_q
          || (ifu_rd_req && ifu_vld_q)
          || ((exec_rd_req || exec_wr_req) && ex_vld_q)
          || (exec_rd_req && exec_wr_req);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      ifu_vld_q     <= 1'b0;
      ifu_addr_q    <= '0;
      ex_vld_q      <= 1'b0;
      ex_wr_q       <= 1'b0;
      ex_addr_q     <= '0;
      ex_data_q     <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      rd_ret_q      <= 1'b0;
      ret_ifu_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;

      ifu_vld_q  <= ifu_cand && !grant_ifu;
      ifu_addr_q <= ifu_addr_sel;
      ex_vld_q   <= ex_cand && !grant_ex;
      ex_wr_q    <= ex_wr_sel;
      ex_addr_q  <= ex_addr_sel;
      ex_data_q  <= ex_data_sel;

      mem_rd_req_q <= (state_d == ISSUE_IFU_RD) || (state_d == ISSUE_EXEC_RD);
      mem_wr_req_q <= (state_d == ISSUE_EXEC_WR);
      case (state_d)
        ISSUE_IFU_RD:  mem_rd_addr_q <= ifu_addr_sel;
        ISSUE_EXEC_RD: mem_rd_addr_q <= ex_addr_sel;
        ISSUE_EXEC_WR: begin
          mem_wr_addr_q <= ex_addr_sel;
          mem_wr_data_q <= ex_data_sel;
        end
        default: ;
      endcase

      rd_ret_q  <= (state_q == ISSUE_IFU_RD) || (state_q == ISSUE_EXEC_RD);
      ret_ifu_q <= (state_q == ISSUE_IFU_RD);
    end
  end

  assign ifu_busy      = ifu_vld_q;
  assign exec_busy     = ex_vld_q;
  assign mem_rd_req    = mem_rd_req_q;
  assign mem_wr_req    = mem_wr_req_q;
  assign mem_rd_addr   = mem_rd_addr_q;
  assign mem_wr_addr   = mem_wr_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign protocol_err  = err_q;
  assign ifu_rd_valid  = rd_ret_q && ret_ifu_q;
  assign exec_rd_valid = rd_ret_q && !ret_ifu_q;
  assign ifu_rd_data   = ifu_rd_valid  ? mem_rd_data : '0;
  assign exec_rd_data  = exec_rd_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, read-data scoreboards per requester, directed timing checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [11:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic        ifu_busy, ifu_rd_valid, exec_busy, exec_rd_valid;
  logic [11:0] ifu_rd_data, exec_rd_data;
  logic        mem_rd_req, mem_wr_req, protocol_err;
  logic [11:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [11:0] mem_rd_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] ifu_q[$];
  logic [11:0] ex_q[$];
  logic [11:0] ref_mem [logic [11:0]];
  logic [11:0] mem_arr [4096];
  logic        mem_seen [4096];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(12), .DATA_WIDTH(12), .IFU_STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_busy(ifu_busy),
    .ifu_rd_valid(ifu_rd_valid), .ifu_rd_data(ifu_rd_data),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .exec_busy(exec_busy), .exec_rd_valid(exec_rd_valid), .exec_rd_data(exec_rd_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .protocol_err(protocol_err)
  );

  function automatic logic [11:0] init_val(input logic [11:0] a);
    return a ^ 12'o7100;
  endfunction

  function automatic logic [11:0] ref_rd(input logic [11:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Single-port memory: write or read per edge, read data registered one cycle later.
  always @(posedge clk) begin
    if (mem_wr_req) begin
      mem_arr[mem_wr_addr]  <= mem_wr_data;
      mem_seen[mem_wr_addr] <= 1'b1;
    end
    if (mem_rd_req)
      mem_rd_data <= mem_seen[mem_rd_addr] ? mem_arr[mem_rd_addr] : init_val(mem_rd_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0o expected %0o (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ifu_rd_valid) begin
        if (ifu_q.size() == 0) check("ifu_unexpected_valid", 32'(ifu_rd_valid), 32'd0);
        else                   check("ifu_rd_data", 32'(ifu_rd_data), 32'(ifu_q.pop_front()));
      end else if (ifu_rd_data != '0) check("ifu_data_idle", 32'(ifu_rd_data), 32'd0);
      if (exec_rd_valid) begin
        if (ex_q.size() == 0) check("exec_unexpected_valid", 32'(exec_rd_valid), 32'd0);
        else                  check("exec_rd_data", 32'(exec_rd_data), 32'(ex_q.pop_front()));
      end else if (exec_rd_data != '0) check("exec_data_idle", 32'(exec_rd_data), 32'd0);
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
    ifu_rd_req = 1'b0; exec_rd_req = 1'b0; exec_wr_req = 1'b0;
  endtask

  task automatic req_ifu(input logic [11:0] a);
    ifu_rd_req = 1'b1; ifu_rd_addr = a;
    ifu_q.push_back(ref_rd(a));
  endtask

  task automatic req_exrd(input logic [11:0] a);
    exec_rd_req = 1'b1; exec_rd_addr = a;
    ex_q.push_back(ref_rd(a));
  endtask

  task automatic req_exwr(input logic [11:0] a, input logic [11:0] d);
    exec_wr_req = 1'b1; exec_wr_addr = a; exec_wr_data = d;
    ref_mem[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'(|{ifu_busy, ifu_rd_valid, ifu_rd_data, exec_busy, exec_rd_valid, exec_rd_data,
                     mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data, protocol_err}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ifu_rd_req = 0; exec_rd_req = 0; exec_wr_req = 0;
    ifu_rd_addr = '0; exec_rd_addr = '0; exec_wr_addr = '0; exec_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    cycle();

    // Lone fetch: issue N+1, data N+2
    req_ifu(12'o0200);
    cycle();
    check("t1_mem_rd_req", 32'(mem_rd_req), 32'd1);
    check("t1_mem_rd_addr", 32'(mem_rd_addr), 32'o0200);
    check("t1_valid_early", 32'(ifu_rd_valid), 32'd0);
    cycle();
    check("t1_ifu_valid", 32'(ifu_rd_valid), 32'd1);
    check("t1_ifu_data", 32'(ifu_rd_data), 32'o7300);
    check("t1_exec_valid", 32'(exec_rd_valid), 32'd0);
    cycle();

    // Contention: exec first, fetch one cycle later
    req_exrd(12'o0050);
    req_ifu(12'o0200);
    cycle();
    check("t2_exec_addr", 32'(mem_rd_addr), 32'o0050);
    check("t2_ifu_busy", 32'(ifu_busy), 32'd1);
    cycle();
    check("t2_ifu_issue", 32'(mem_rd_req), 32'd1);
    check("t2_ifu_addr", 32'(mem_rd_addr), 32'o0200);
    check("t2_exec_valid", 32'(exec_rd_valid), 32'd1);
    check("t2_ifu_busy_clr", 32'(ifu_busy), 32'd0);
    cycle();
    check("t2_ifu_valid", 32'(ifu_rd_valid), 32'd1);
    cycle();

    // Write wins, then fetch sees the new data
    req_exwr(12'o0050, 12'o1234);
    req_ifu(12'o0050);
    cycle();
    check("t3_wr_req", 32'(mem_wr_req), 32'd1);
    check("t3_wr_addr", 32'(mem_wr_addr), 32'o0050);
    check("t3_wr_data", 32'(mem_wr_data), 32'o1234);
    check("t3_rd_idle", 32'(mem_rd_req), 32'd0);
    cycle();
    check("t3_ifu_addr", 32'(mem_rd_addr), 32'o0050);
    cycle();
    check("t3_ifu_data", 32'(ifu_rd_data), 32'o1234);
    cycle();

    // Starvation: four exec grants then forced fetch
    req_ifu(12'o0300);
    for (int unsigned k = 0; k < 5; k++) begin
      req_exrd(12'o0010 + 12'(k));
      cycle();
      if (k < 4) check("t4_exec_grant", 32'(mem_rd_addr), 32'(12'o0010 + 12'(k)));
    end
    check("t4_forced_ifu", 32'(mem_rd_addr), 32'o0300);
    check("t4_exec_held", 32'(exec_busy), 32'd1);
    cycle();
    check("t4_exec_after", 32'(mem_rd_addr), 32'o0014);
    req_ifu(12'o0301);
    req_exrd(12'o0020);
    cycle();
    check("t4_cnt_cleared", 32'(mem_rd_addr), 32'o0020);
    cycle();
    check("t4_ifu_next", 32'(mem_rd_addr), 32'o0301);
    repeat (3) cycle();

    // Request while busy is dropped and flags an error
    check("t5_err_clear", 32'(protocol_err), 32'd0);
    req_ifu(12'o0400);
    req_exrd(12'o0061);
    cycle();
    check("t5_busy", 32'(ifu_busy), 32'd1);
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0500;
    cycle();
    check("t5_slot_kept", 32'(mem_rd_addr), 32'o0400);
    check("t5_err_set", 32'(protocol_err), 32'd1);
    repeat (3) cycle();
    check("t5_err_sticky", 32'(protocol_err), 32'd1);
    check("t5_no_extra_rd", 32'(mem_rd_req), 32'd0);

    reset_n = 1'b0; #1;
    check("t5_err_reset", 32'(protocol_err), 32'd0);
    cycle();
    reset_n = 1'b1;
    cycle();

    // Simultaneous exec read and write: write only
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0060;
    req_exwr(12'o0070, 12'o4321);
    cycle();
    check("t5b_wr_req", 32'(mem_wr_req), 32'd1);
    check("t5b_wr_addr", 32'(mem_wr_addr), 32'o0070);
    check("t5b_rd_req", 32'(mem_rd_req), 32'd0);
    check("t5b_err", 32'(protocol_err), 32'd1);
    check("t5b_slot_empty", 32'(exec_busy), 32'd0);
    cycle();
    check("t5b_no_rd", 32'(mem_rd_req | mem_wr_req), 32'd0);
    req_exrd(12'o0070);
    cycle();
    repeat (2) cycle();

    // Reset while a read is in flight
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
    cycle();
    check("t6_rd_issued", 32'(mem_rd_req), 32'd1);
    reset_n = 1'b0; #1;
    check_all_zero("t6_reset_outputs");
    cycle();
    check("t6_no_valid", 32'(ifu_rd_valid), 32'd0);
    reset_n = 1'b1;
    cycle();
    check("t6_no_valid_after", 32'(ifu_rd_valid), 32'd0);
    req_ifu(12'o0200);
    cycle();
    check("t6_reissue", 32'(mem_rd_req), 32'd1);
    cycle();
    check("t6_valid", 32'(ifu_rd_valid), 32'd1);
    cycle();

    // Random legal traffic; fetch and exec-write address ranges kept disjoint
    for (int unsigned c = 0; c < 300; c++) begin
      if (!ifu_busy && ($urandom_range(0, 1) == 1))
        req_ifu(12'($urandom_range(0, 63)));
      if (!exec_busy && ($urandom_range(0, 2) != 0)) begin
        if ($urandom_range(0, 1) == 1) req_exwr(12'($urandom_range(64, 127)), 12'($urandom));
        else                           req_exrd(12'($urandom_range(0, 127)));
      end
      cycle();
    end

    for (int unsigned w = 0; w < 20 && (ifu_q.size() != 0 || ex_q.size() != 0); w++) cycle();
    check("drain_ifu", 32'(ifu_q.size()), 32'd0);
    check("drain_exec", 32'(ex_q.size()), 32'd0);
    check("final_err", 32'(protocol_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
